// File: rtl/hazard_scoreboard.sv
// Hazard unit for the in-order core: M/W forwarding, load-use stall, branch flush and long-op scoreboard.
// Controls are combinational; pending bits appear one clk after issue; stall holds F/D, flush bubbles D/E.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter bit WB_BYPASS  = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REG_ADDR_W-1:0]         rs1_d,
  input  logic [REG_ADDR_W-1:0]         rs2_d,
  input  logic [REG_ADDR_W-1:0]         rd_d,
  input  logic                          valid_d,
  input  logic                          use_rs1_d,
  input  logic                          use_rs2_d,
  input  logic                          reg_write_d,
  input  logic                          long_op_d,
  input  logic                          long_busy,
  input  logic                          long_wb_valid,
  input  logic [REG_ADDR_W-1:0]         long_wb_rd,
  input  logic [REG_ADDR_W-1:0]         rs1_e,
  input  logic [REG_ADDR_W-1:0]         rs2_e,
  input  logic [REG_ADDR_W-1:0]         rd_e,
  input  logic                          use_rs1_e,
  input  logic                          use_rs2_e,
  input  logic                          load_e,
  input  logic                          pc_src_e,
  input  logic [REG_ADDR_W-1:0]         rd_m,
  input  logic [REG_ADDR_W-1:0]         rd_w,
  input  logic                          reg_write_m,
  input  logic                          reg_write_w,
  output logic                          stall_f,
  output logic                          stall_d,
  output logic                          flush_d,
  output logic                          flush_e,
  output logic [1:0]                    forward_a_e,
  output logic [1:0]                    forward_b_e,
  output logic [(2**REG_ADDR_W)-1:0]    pending,
  output logic [CNT_W-1:0]              stall_cycles
);

  localparam int                    NUM_REGS = 2**REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] X0       = '0;
  localparam logic [NUM_REGS-1:0]   NOT_X0   = {{(NUM_REGS-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

  logic [NUM_REGS-1:0] wb_onehot;
  logic [NUM_REGS-1:0] eff;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                load_use;
  logic                raw;
  logic                waw;
  logic                struct_haz;
  logic                stall;
  logic                issue;

  // M wins over W because it holds the younger result for the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  src_used,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic                  w_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src_used && (rs != X0)) begin
      if (m_we && (m_rd == rs)) begin
        sel = 2'b10;
      end else if (w_we && (w_rd == rs)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  assign forward_a_e = fwd_sel(rs1_e, use_rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign forward_b_e = fwd_sel(rs2_e, use_rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

  always_comb begin
    wb_onehot = '0;
    if (long_wb_valid) begin
      wb_onehot[long_wb_rd] = 1'b1;
    end
  end

  // A write-through regfile lets the consumer read the long-op result in its writeback cycle.
  assign eff = pending & ~({NUM_REGS{WB_BYPASS}} & wb_onehot) & NOT_X0;

  assign load_use   = load_e && (rd_e != X0) &&
                      ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));
  assign raw        = (use_rs1_d && eff[rs1_d]) || (use_rs2_d && eff[rs2_d]);
  assign waw        = reg_write_d && eff[rd_d];
  assign struct_haz = long_op_d && long_busy;

  assign stall   = valid_d && (load_use || raw || waw || struct_haz);
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_d = pc_src_e;
  assign flush_e = stall || pc_src_e;

  // A long op squashed by a taken branch in E never reaches the unit, so it must not be tracked.
  assign issue = valid_d && !stall && !pc_src_e && long_op_d && reg_write_d && (rd_d != X0);

  always_comb begin
    pending_nxt = pending;
    if (long_wb_valid) begin
      pending_nxt[long_wb_rd] = 1'b0;
    end
    if (issue) begin
      pending_nxt[rd_d] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three instances (bypass, no-bypass, 4-bit counter) checked against a rule model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0, long_wb_rd = '0;
  logic [4:0] rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
  logic       valid_d = 1'b0, use_rs1_d = 1'b0, use_rs2_d = 1'b0, reg_write_d = 1'b0;
  logic       long_op_d = 1'b0, long_busy = 1'b0, long_wb_valid = 1'b0;
  logic       use_rs1_e = 1'b0, use_rs2_e = 1'b0, load_e = 1'b0, pc_src_e = 1'b0;
  logic       reg_write_m = 1'b0, reg_write_w = 1'b0;

  logic        stall_f_o [3];
  logic        stall_d_o [3];
  logic        flush_d_o [3];
  logic        flush_e_o [3];
  logic [1:0]  fa_o [3];
  logic [1:0]  fb_o [3];
  logic [31:0] pend_o [3];
  logic [31:0] cnt_o [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CW = (k == 2) ? 4 : 32;
    logic [CW-1:0] cnt;
    hazard_scoreboard #(
      .REG_ADDR_W(5),
      .WB_BYPASS((k == 1) ? 1'b0 : 1'b1),
      .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst(rst),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .valid_d(valid_d),
      .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .reg_write_d(reg_write_d),
      .long_op_d(long_op_d), .long_busy(long_busy),
      .long_wb_valid(long_wb_valid), .long_wb_rd(long_wb_rd),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .use_rs1_e(use_rs1_e), .use_rs2_e(use_rs2_e), .load_e(load_e), .pc_src_e(pc_src_e),
      .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .stall_f(stall_f_o[k]), .stall_d(stall_d_o[k]),
      .flush_d(flush_d_o[k]), .flush_e(flush_e_o[k]),
      .forward_a_e(fa_o[k]), .forward_b_e(fb_o[k]),
      .pending(pend_o[k]), .stall_cycles(cnt)
    );
    assign cnt_o[k] = 32'(cnt);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mp [3] = '{32'd0, 32'd0, 32'd0};
  longint      mc [3] = '{0, 0, 0};

  function automatic bit eff_m(input logic [31:0] pend, input bit byp, input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (byp && long_wb_valid && (long_wb_rd == r)) return 1'b0;
    return pend[r];
  endfunction

  function automatic bit stall_m(input logic [31:0] pend, input bit byp);
    bit lu;
    lu = load_e && (rd_e != 5'd0) &&
         ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));
    return valid_d && (lu || (use_rs1_d && eff_m(pend, byp, rs1_d)) ||
                       (use_rs2_d && eff_m(pend, byp, rs2_d)) ||
                       (reg_write_d && eff_m(pend, byp, rd_d)) || (long_op_d && long_busy));
  endfunction

  function automatic logic [31:0] next_m(input logic [31:0] pend, input bit st);
    logic [31:0] n;
    n = pend;
    if (long_wb_valid) n[long_wb_rd] = 1'b0;
    if (valid_d && !st && !pc_src_e && long_op_d && reg_write_d && (rd_d != 5'd0)) n[rd_d] = 1'b1;
    n[0] = 1'b0;
    return n;
  endfunction

  function automatic logic [1:0] fwd_m(input logic [4:0] rs, input logic u);
    if (!u || (rs == 5'd0)) return 2'b00;
    if (reg_write_m && (rd_m == rs)) return 2'b10;
    if (reg_write_w && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic longint cmax(input int k);
    return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl_upd
    bit st;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mp[k] = '0;
        mc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        st = stall_m(mp[k], k != 1);
        if (st && (mc[k] < cmax(k))) mc[k] = mc[k] + 1;
        mp[k] = next_m(mp[k], st);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit st;
    for (int k = 0; k < 3; k++) begin
      st = stall_m(mp[k], k != 1);
      chk($sformatf("u%0d.stall_f", k), 64'(stall_f_o[k]), 64'(st));
      chk($sformatf("u%0d.stall_d", k), 64'(stall_d_o[k]), 64'(st));
      chk($sformatf("u%0d.flush_d", k), 64'(flush_d_o[k]), 64'(pc_src_e));
      chk($sformatf("u%0d.flush_e", k), 64'(flush_e_o[k]), 64'(st || pc_src_e));
      chk($sformatf("u%0d.fwd_a", k), 64'(fa_o[k]), 64'(fwd_m(rs1_e, use_rs1_e)));
      chk($sformatf("u%0d.fwd_b", k), 64'(fb_o[k]), 64'(fwd_m(rs2_e, use_rs2_e)));
      chk($sformatf("u%0d.pending", k), 64'(pend_o[k]), 64'(mp[k]));
      chk($sformatf("u%0d.stall_cycles", k), 64'(cnt_o[k]), 64'(mc[k]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rd_d = '0; valid_d = 1'b0; use_rs1_d = 1'b0; use_rs2_d = 1'b0;
    reg_write_d = 1'b0; long_op_d = 1'b0; long_busy = 1'b0; long_wb_valid = 1'b0; long_wb_rd = '0;
    rs1_e = '0; rs2_e = '0; rd_e = '0; use_rs1_e = 1'b0; use_rs2_e = 1'b0; load_e = 1'b0;
    pc_src_e = 1'b0; rd_m = '0; rd_w = '0; reg_write_m = 1'b0; reg_write_w = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_pending", 64'(pend_o[0]), 64'h0);
    chk("rst_cnt", 64'(cnt_o[0]), 64'h0);
    chk("rst_stall", 64'(stall_d_o[0]), 64'h0);
    tick(); tick();
    rst = 1'b0;

    // structural stall held for 10 then 20 cycles
    valid_d = 1'b1; long_op_d = 1'b1; long_busy = 1'b1; reg_write_d = 1'b1; rd_d = 5'd3;
    #1;
    chk("struct_stall", 64'(stall_d_o[0]), 64'h1);
    chk("struct_flush_e", 64'(flush_e_o[0]), 64'h1);
    repeat (10) tick();
    #1;
    chk("cnt10_u0", 64'(cnt_o[0]), 64'd10);
    chk("cnt10_u2", 64'(cnt_o[2]), 64'd10);
    repeat (10) tick();
    #1;
    chk("cnt20_u0", 64'(cnt_o[0]), 64'd20);
    chk("cnt_sat_u2", 64'(cnt_o[2]), 64'd15);
    chk("struct_no_issue", 64'(pend_o[0]), 64'h0);

    // load-use
    idle(); load_e = 1'b1; rd_e = 5'd5; valid_d = 1'b1; use_rs2_d = 1'b1; rs2_d = 5'd5;
    use_rs1_d = 1'b1; rs1_d = 5'd1; reg_write_d = 1'b1; rd_d = 5'd10;
    #1;
    chk("lu_stall_f", 64'(stall_f_o[0]), 64'h1);
    chk("lu_flush_e", 64'(flush_e_o[0]), 64'h1);
    chk("lu_flush_d", 64'(flush_d_o[0]), 64'h0);
    tick();
    idle(); valid_d = 1'b1; rd_m = 5'd5; reg_write_m = 1'b1; rs2_e = 5'd5; use_rs2_e = 1'b1;
    rs1_e = 5'd1; use_rs1_e = 1'b1;
    #1;
    chk("lu_fwd_b", 64'(fb_o[0]), 64'h2);
    chk("lu_fwd_a", 64'(fa_o[0]), 64'h0);
    chk("lu_released", 64'(stall_d_o[0]), 64'h0);
    tick();
    idle(); load_e = 1'b1; rd_e = 5'd0; valid_d = 1'b1; use_rs2_d = 1'b1; rs2_d = 5'd0;
    #1;
    chk("lu_x0", 64'(stall_d_o[0]), 64'h0);
    tick();
    idle(); load_e = 1'b1; rd_e = 5'd5; valid_d = 1'b1; rs2_d = 5'd5;
    #1;
    chk("lu_unused_src", 64'(stall_d_o[0]), 64'h0);
    tick();

    // forwarding priority
    idle(); rd_m = 5'd7; rd_w = 5'd7; reg_write_m = 1'b1; reg_write_w = 1'b1; rs1_e = 5'd7; use_rs1_e = 1'b1;
    #1; chk("fwd_m_prio", 64'(fa_o[0]), 64'h2);
    tick(); reg_write_m = 1'b0;
    #1; chk("fwd_w", 64'(fa_o[0]), 64'h1);
    tick(); rs1_e = 5'd0;
    #1; chk("fwd_x0", 64'(fa_o[0]), 64'h0);
    tick(); rs1_e = 5'd7; use_rs1_e = 1'b0;
    #1; chk("fwd_unused", 64'(fa_o[0]), 64'h0);
    tick();

    // long-op RAW, bypass vs no bypass
    idle(); valid_d = 1'b1; long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd9;
    #1; chk("div_issue_nostall", 64'(stall_d_o[0]), 64'h0);
    tick();
    idle(); valid_d = 1'b1; use_rs1_d = 1'b1; rs1_d = 5'd9; reg_write_d = 1'b1; rd_d = 5'd11;
    #1;
    chk("div_pend_u0", 64'(pend_o[0]), 64'h200);
    chk("div_pend_u1", 64'(pend_o[1]), 64'h200);
    chk("raw_stall_u0", 64'(stall_d_o[0]), 64'h1);
    chk("raw_stall_u1", 64'(stall_d_o[1]), 64'h1);
    tick();
    long_wb_valid = 1'b1; long_wb_rd = 5'd9;
    #1;
    chk("wb_byp_release", 64'(stall_d_o[0]), 64'h0);
    chk("wb_nobyp_hold", 64'(stall_d_o[1]), 64'h1);
    chk("wb_pend_still", 64'(pend_o[0]), 64'h200);
    tick();
    long_wb_valid = 1'b0;
    #1;
    chk("wb_clr_u0", 64'(pend_o[0]), 64'h0);
    chk("wb_clr_u1", 64'(pend_o[1]), 64'h0);
    chk("nobyp_release", 64'(stall_d_o[1]), 64'h0);
    tick();

    // WAW and structural with a pending x3
    idle(); valid_d = 1'b1; long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd3;
    tick();
    idle(); valid_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd3;
    #1;
    chk("waw_pend", 64'(pend_o[0]), 64'h8);
    chk("waw_stall", 64'(stall_d_o[0]), 64'h1);
    tick(); long_op_d = 1'b1; long_busy = 1'b1; rd_d = 5'd12;
    #1; chk("busy_stall", 64'(stall_d_o[0]), 64'h1);
    tick(); long_busy = 1'b0;
    #1; chk("busy_drop", 64'(stall_d_o[0]), 64'h0);
    tick(); rd_d = 5'd0;
    #1; chk("issue_x12", 64'(pend_o[0]), 64'h1008);
    tick(); idle();
    #1; chk("issue_x0_none", 64'(pend_o[0]), 64'h1008);
    long_wb_valid = 1'b1; long_wb_rd = 5'd0;
    tick(); #1; chk("wb_x0", 64'(pend_o[0]), 64'h1008);
    long_wb_rd = 5'd20;
    tick(); #1; chk("wb_not_pending", 64'(pend_o[0]), 64'h1008);
    long_wb_rd = 5'd3;
    tick(); #1; chk("wb_x3", 64'(pend_o[0]), 64'h1000);
    long_wb_rd = 5'd12;
    tick(); #1; chk("wb_x12", 64'(pend_o[0]), 64'h0);
    long_wb_valid = 1'b0;

    // branch flush vs issue
    idle(); valid_d = 1'b1; long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd6;
    tick();
    idle(); valid_d = 1'b1; long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd4; pc_src_e = 1'b1;
    #1;
    chk("br_flush_d", 64'(flush_d_o[0]), 64'h1);
    chk("br_flush_e", 64'(flush_e_o[0]), 64'h1);
    tick();
    idle(); valid_d = 1'b1; use_rs1_d = 1'b1; rs1_d = 5'd6; pc_src_e = 1'b1;
    #1;
    chk("br_no_x4", 64'(pend_o[0]), 64'h40);
    chk("br_stall_kept", 64'(stall_d_o[0]), 64'h1);
    chk("br_flush_kept", 64'(flush_d_o[0]), 64'h1);
    tick();
    idle(); long_wb_valid = 1'b1; long_wb_rd = 5'd6;
    tick(); idle();
    #1; chk("br_x6_cleared", 64'(pend_o[0]), 64'h0);

    // asynchronous reset mid-run
    valid_d = 1'b1; long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd6;
    tick(); rd_d = 5'd9;
    tick(); idle();
    #1;
    chk("pre_rst_pend", 64'(pend_o[0]), 64'h240);
    chk("pre_rst_cnt_nz", 64'(cnt_o[0] != 32'd0), 64'h1);
    rst = 1'b1;
    #1;
    chk("arst_pend_u0", 64'(pend_o[0]), 64'h0);
    chk("arst_pend_u1", 64'(pend_o[1]), 64'h0);
    chk("arst_cnt_u0", 64'(cnt_o[0]), 64'h0);
    chk("arst_cnt_u2", 64'(cnt_o[2]), 64'h0);
    tick();
    rst = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
    $fatal(1);
  end

endmodule
